// File: rtl/wb_epbuf_mux.sv
// Wishbone slave bridging onto NP endpoint-buffer RAM ports; partial writes become read-modify-write.
// Latency from request sample to ack: full write 2, read RL+1, partial write RL+2, empty-select write 1.
module wb_epbuf_mux #(
  parameter int AW = 9,
  parameter int DW = 32,
  parameter int NP = 2,
  parameter int RL = 1,
  localparam int PW = (NP > 1) ? $clog2(NP) : 1,
  localparam int SW = DW / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW+PW-1:0] wb_addr,
  output logic [DW-1:0]    wb_rdata,
  input  logic [DW-1:0]    wb_wdata,
  input  logic [SW-1:0]    wb_sel,
  input  logic             wb_we,
  input  logic             wb_cyc,
  output logic             wb_ack,
  output logic             wb_err,
  output logic [NP*AW-1:0] ep_tx_addr_0,
  output logic [NP*AW-1:0] ep_rx_addr_0,
  output logic [NP*DW-1:0] ep_tx_data_0,
  output logic [NP-1:0]    ep_tx_we_0,
  input  logic [NP*DW-1:0] ep_rx_data_1,
  output logic [NP-1:0]    ep_rx_re_0
);

  typedef enum logic [2:0] {
    IDLE, RD, RMW_RD, WR, ACK, ERR
  } state_t;

  localparam int CW = 3;

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] wd,
                                                input logic [DW-1:0] rd,
                                                input logic [SW-1:0] sel);
    logic [DW-1:0] m;
    m = rd;
    for (int b = 0; b < SW; b++) begin
      if (sel[b]) m[b*8 +: 8] = wd[b*8 +: 8];
    end
    return m;
  endfunction

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW+PW-1:0]    addr_q, addr_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic                we_q, we_d;
  logic [DW-1:0]       wdat_q, wdat_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [PW-1:0]       pidx;
  logic [DW-1:0]       rx_sel;

  assign pidx = addr_q[AW+PW-1:AW];

  always_comb begin
    rx_sel = '0;
    for (int p = 0; p < NP; p++) begin
      if (int'(pidx) == p) rx_sel = ep_rx_data_1[p*DW +: DW];
    end
  end

  // Strobes decode straight from state so a reset drops them without waiting for an edge.
  always_comb begin
    ep_rx_re_0 = '0;
    ep_tx_we_0 = '0;
    for (int p = 0; p < NP; p++) begin
      if (int'(pidx) == p) begin
        ep_rx_re_0[p] = (state_q == RD) || (state_q == RMW_RD);
        ep_tx_we_0[p] = (state_q == WR);
      end
    end
  end

  assign ep_tx_addr_0 = {NP{addr_q[AW-1:0]}};
  assign ep_rx_addr_0 = {NP{addr_q[AW-1:0]}};
  assign ep_tx_data_0 = {NP{wdat_q}};
  assign wb_rdata     = rdata_q;
  assign wb_ack       = (state_q == ACK);
  assign wb_err       = (state_q == ERR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (wb_cyc) begin
          addr_d = wb_addr;
          sel_d  = wb_sel;
          we_d   = wb_we;
          wdat_d = wb_wdata;
          if (int'(wb_addr[AW+PW-1:AW]) >= NP) begin
            state_d = ERR;
          end else if (!wb_we) begin
            state_d = RD;
            cnt_d   = CW'(RL - 1);
          end else if (&wb_sel) begin
            state_d = WR;
          end else if (wb_sel == '0) begin
            state_d = ACK;
          end else begin
            state_d = RMW_RD;
            cnt_d   = CW'(RL - 1);
          end
        end
      end
      RD, RMW_RD: begin
        if (cnt_q == '0) begin
          if (we_q) begin
            wdat_d  = merge_bytes(wdat_q, rx_sel, sel_q);
            state_d = WR;
          end else begin
            rdata_d = rx_sel;
            state_d = ACK;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR:      state_d = ACK;
      ACK:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_wb_epbuf_mux.sv
// Directed bench for wb_epbuf_mux: three instances (NP=2/RL=1, NP=3/RL=3, NP=1/RL=1) with EP-buf RAM models.
module tb_wb_epbuf_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [10:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        cyc_a, cyc_b, cyc_c;

  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        ack_a, ack_b, ack_c, err_a, err_b, err_c;
  logic [17:0] txa_a, rxa_a;
  logic [26:0] txa_b, rxa_b;
  logic [8:0]  txa_c, rxa_c;
  logic [63:0] txd_a, rxd_a;
  logic [95:0] txd_b, rxd_b;
  logic [31:0] txd_c, rxd_c;
  logic [1:0]  we_a, re_a;
  logic [2:0]  we_b, re_b;
  logic [0:0]  we_c, re_c;

  wb_epbuf_mux #(.AW(9), .DW(32), .NP(2), .RL(1)) u_a (
    .clk(clk), .rst(rst), .wb_addr(wb_addr[9:0]), .wb_rdata(rdata_a), .wb_wdata(wb_wdata),
    .wb_sel(wb_sel), .wb_we(wb_we), .wb_cyc(cyc_a), .wb_ack(ack_a), .wb_err(err_a),
    .ep_tx_addr_0(txa_a), .ep_rx_addr_0(rxa_a), .ep_tx_data_0(txd_a), .ep_tx_we_0(we_a),
    .ep_rx_data_1(rxd_a), .ep_rx_re_0(re_a));

  wb_epbuf_mux #(.AW(9), .DW(32), .NP(3), .RL(3)) u_b (
    .clk(clk), .rst(rst), .wb_addr(wb_addr), .wb_rdata(rdata_b), .wb_wdata(wb_wdata),
    .wb_sel(wb_sel), .wb_we(wb_we), .wb_cyc(cyc_b), .wb_ack(ack_b), .wb_err(err_b),
    .ep_tx_addr_0(txa_b), .ep_rx_addr_0(rxa_b), .ep_tx_data_0(txd_b), .ep_tx_we_0(we_b),
    .ep_rx_data_1(rxd_b), .ep_rx_re_0(re_b));

  wb_epbuf_mux #(.AW(9), .DW(32), .NP(1), .RL(1)) u_c (
    .clk(clk), .rst(rst), .wb_addr(wb_addr[9:0]), .wb_rdata(rdata_c), .wb_wdata(wb_wdata),
    .wb_sel(wb_sel), .wb_we(wb_we), .wb_cyc(cyc_c), .wb_ack(ack_c), .wb_err(err_c),
    .ep_tx_addr_0(txa_c), .ep_rx_addr_0(rxa_c), .ep_tx_data_0(txd_c), .ep_tx_we_0(we_c),
    .ep_rx_data_1(rxd_c), .ep_rx_re_0(re_c));

  // RAM models: data is sampled by the DUT on the RL-th edge after re first rises.
  logic [31:0] mem_a [2][512];
  logic [31:0] mem_b [3][512];
  logic [95:0] vb0, vb1, vb2;

  always @(posedge clk) begin
    for (int p = 0; p < 2; p++)
      if (we_a[p]) mem_a[p][txa_a[p*9 +: 9]] <= txd_a[p*32 +: 32];
    for (int p = 0; p < 3; p++)
      if (we_b[p]) mem_b[p][txa_b[p*9 +: 9]] <= txd_b[p*32 +: 32];
    vb1 <= vb0;
    vb2 <= vb1;
  end

  always_comb begin
    rxd_a = '0;
    for (int p = 0; p < 2; p++)
      rxd_a[p*32 +: 32] = re_a[p] ? mem_a[p][rxa_a[p*9 +: 9]] : (32'hDEAD_0000 | 32'(p));
    vb0 = '0;
    for (int p = 0; p < 3; p++)
      vb0[p*32 +: 32] = re_b[p] ? mem_b[p][rxa_b[p*9 +: 9]] : (32'hDEAD_0000 | 32'(p));
  end

  assign rxd_b = vb2;
  assign rxd_c = re_c[0] ? 32'h5A5A_0F0F : 32'h0BAD_0BAD;

  int          dsel;
  logic [7:0]  m_re, m_we;
  logic        m_ack, m_err;
  logic [31:0] m_txd, m_rd;
  logic [8:0]  m_txa, m_rxa;

  always_comb begin
    m_re = '0; m_we = '0; m_ack = 1'b0; m_err = 1'b0;
    m_txd = '0; m_rd = '0; m_txa = '0; m_rxa = '0;
    case (dsel)
      0: begin m_re = 8'(re_a); m_we = 8'(we_a); m_ack = ack_a; m_err = err_a;
               m_txd = txd_a[31:0]; m_rd = rdata_a; m_txa = txa_a[8:0]; m_rxa = rxa_a[8:0]; end
      1: begin m_re = 8'(re_b); m_we = 8'(we_b); m_ack = ack_b; m_err = err_b;
               m_txd = txd_b[31:0]; m_rd = rdata_b; m_txa = txa_b[8:0]; m_rxa = rxa_b[8:0]; end
      default: begin m_re = 8'(re_c); m_we = 8'(we_c); m_ack = ack_c; m_err = err_c;
               m_txd = txd_c; m_rd = rdata_c; m_txa = txa_c; m_rxa = rxa_c; end
    endcase
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          r_ack_at, r_ack_n, r_err_at, r_err_n, r_re_n, r_we_n, r_both;
  logic [7:0]  r_re_or, r_we_or;
  logic [31:0] r_we_dat;
  logic [8:0]  r_re_addr, r_we_addr;

  // One request, then watch a fixed 12-cycle window; k counts edges after the sampling edge.
  task automatic txn(input int d, input logic [10:0] a, input logic we,
                     input logic [3:0] s, input logic [31:0] wd);
    @(negedge clk);
    dsel = d; wb_addr = a; wb_we = we; wb_sel = s; wb_wdata = wd;
    cyc_a = (d == 0); cyc_b = (d == 1); cyc_c = (d == 2);
    @(posedge clk);
    #1 cyc_a = 1'b0; cyc_b = 1'b0; cyc_c = 1'b0;
    r_ack_at = -1; r_ack_n = 0; r_err_at = -1; r_err_n = 0; r_re_n = 0; r_we_n = 0; r_both = 0;
    r_re_or = '0; r_we_or = '0; r_we_dat = '0; r_re_addr = '0; r_we_addr = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (m_ack) begin r_ack_n++; if (r_ack_at < 0) r_ack_at = k; end
      if (m_err) begin r_err_n++; if (r_err_at < 0) r_err_at = k; end
      if (m_ack && m_err) r_both++;
      if (m_re != 0) begin r_re_n++; r_re_or |= m_re; r_re_addr = m_rxa; end
      if (m_we != 0) begin r_we_n++; r_we_or |= m_we; r_we_dat = m_txd; r_we_addr = m_txa; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   x_ack, x_we;
    rst = 1'b1; cyc_a = 0; cyc_b = 0; cyc_c = 0; dsel = 0;
    wb_addr = '0; wb_wdata = '0; wb_sel = '0; wb_we = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(m_ack), 0);
    chk("rst_err", 32'(m_err), 0);
    chk("rst_rdata", m_rd, 0);
    chk("rst_re", 32'(m_re), 0);
    chk("rst_we", 32'(m_we), 0);
    chk("rst_txd", m_txd, 0);
    chk("rst_txa", 32'(m_txa), 0);
    @(negedge clk) rst = 1'b0;

    // A: full write port1 addr 5, then read it back
    txn(0, {1'b0, 1'b1, 9'h005}, 1'b1, 4'hF, 32'hCAFE_BABE);
    chk("a_fw1_ack_at", r_ack_at, 2);
    chk("a_fw1_we", 32'(r_we_or), 32'h2);
    chk("a_fw1_we_n", r_we_n, 1);
    chk("a_fw1_re_n", r_re_n, 0);
    txn(0, {1'b0, 1'b1, 9'h005}, 1'b0, 4'hF, 32'h0);
    chk("a_rd_re", 32'(r_re_or), 32'h2);
    chk("a_rd_re_n", r_re_n, 1);
    chk("a_rd_addr", 32'(r_re_addr), 32'h005);
    chk("a_rd_ack_at", r_ack_at, 2);
    chk("a_rd_ack_n", r_ack_n, 1);
    chk("a_rd_data", m_rd, 32'hCAFE_BABE);

    // A: full write port0 addr 0x1FF
    txn(0, {1'b0, 1'b0, 9'h1FF}, 1'b1, 4'hF, 32'h1234_5678);
    chk("a_fw0_we", 32'(r_we_or), 32'h1);
    chk("a_fw0_we_n", r_we_n, 1);
    chk("a_fw0_dat", r_we_dat, 32'h1234_5678);
    chk("a_fw0_addr", 32'(r_we_addr), 32'h1FF);
    chk("a_fw0_ack_at", r_ack_at, 2);
    chk("a_fw0_rdata_hold", m_rd, 32'hCAFE_BABE);

    // A: sel=0 write is acked with no strobes and leaves RAM and rdata alone
    txn(0, {1'b0, 1'b0, 9'h1FF}, 1'b1, 4'h0, 32'hFFFF_FFFF);
    chk("a_z_ack_at", r_ack_at, 1);
    chk("a_z_we_n", r_we_n, 0);
    chk("a_z_re_n", r_re_n, 0);
    chk("a_z_rdata", m_rd, 32'hCAFE_BABE);
    txn(0, {1'b0, 1'b0, 9'h1FF}, 1'b0, 4'hF, 32'h0);
    chk("a_rd0_data", m_rd, 32'h1234_5678);
    chk("a_rd0_re", 32'(r_re_or), 32'h1);

    // C: NP=1, index bit set -> error; valid read works
    txn(2, 11'h200, 1'b0, 4'hF, 32'h0);
    chk("c_err_at", r_err_at, 1);
    chk("c_err_n", r_err_n, 1);
    chk("c_err_ack_n", r_ack_n, 0);
    chk("c_err_re_n", r_re_n, 0);
    txn(2, 11'h003, 1'b0, 4'hF, 32'h0);
    chk("c_rd_ack_at", r_ack_at, 2);
    chk("c_rd_data", m_rd, 32'h5A5A_0F0F);

    // B: NP=3 RL=3, seed word then partial write sel=0101
    txn(1, {2'd2, 9'h010}, 1'b1, 4'hF, 32'hAABB_CCDD);
    chk("b_fw_ack_at", r_ack_at, 2);
    chk("b_fw_we", 32'(r_we_or), 32'h4);
    txn(1, {2'd2, 9'h010}, 1'b1, 4'b0101, 32'h1122_3344);
    chk("b_pw_re_n", r_re_n, 3);
    chk("b_pw_re", 32'(r_re_or), 32'h4);
    chk("b_pw_we_n", r_we_n, 1);
    chk("b_pw_dat", r_we_dat, 32'hAA22_CC44);
    chk("b_pw_ack_at", r_ack_at, 5);
    chk("b_pw_both", r_both, 0);
    txn(1, {2'd2, 9'h010}, 1'b0, 4'hF, 32'h0);
    chk("b_rd_ack_at", r_ack_at, 4);
    chk("b_rd_data", m_rd, 32'hAA22_CC44);

    // B: port index 3 with NP=3 -> error
    txn(1, {2'd3, 9'h000}, 1'b1, 4'hF, 32'h5555_5555);
    chk("b_err_at", r_err_at, 1);
    chk("b_err_n", r_err_n, 1);
    chk("b_err_ack_n", r_ack_n, 0);
    chk("b_err_strobes", 32'(r_re_n + r_we_n), 0);

    // B: reset during RMW_RD aborts, then a read still completes
    @(negedge clk);
    dsel = 1; wb_addr = {2'd2, 9'h010}; wb_we = 1'b1; wb_sel = 4'b0011; wb_wdata = 32'h9988_7766;
    cyc_b = 1'b1;
    @(posedge clk);
    #1 cyc_b = 1'b0;
    @(negedge clk);
    chk("b_rst_re_live", 32'(m_re), 32'h4);
    rst = 1'b1;
    #1;
    chk("b_rst_re_drop", 32'(m_re), 0);
    chk("b_rst_we_drop", 32'(m_we), 0);
    x_ack = 0; x_we = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) rst = 1'b0;
      if (m_ack) x_ack++;
      if (m_we != 0) x_we++;
    end
    chk("b_rst_no_ack", x_ack, 0);
    chk("b_rst_no_we", x_we, 0);
    chk("b_rst_rdata", m_rd, 0);
    txn(1, {2'd2, 9'h010}, 1'b0, 4'hF, 32'h0);
    chk("b_post_ack_at", r_ack_at, 4);
    chk("b_post_data", m_rd, 32'hAA22_CC44);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_epbuf_mux.md
WB_EPBUF_MUX -- requirements
Module: wb_epbuf_mux

Interface
REQ-001 SHALL have parameter AW, default 9: EP-buf word address width.
REQ-002 SHALL have parameter DW, default 32: data width, a multiple of 8.
REQ-003 SHALL have parameter NP, default 2: number of EP-buf ports, 1..8.
REQ-004 SHALL have parameter RL, default 1: EP-buf read latency in cycles, 1..4.
REQ-005 SHALL define derived localparams PW = max(1, clog2(NP)) and SW = DW/8.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port wb_addr, input, AW+PW: port index in [AW+PW-1:AW], word address in [AW-1:0].
REQ-009 SHALL have port wb_rdata, output, DW: read data.
REQ-010 SHALL have port wb_wdata, input, DW: write data.
REQ-011 SHALL have port wb_sel, input, SW: byte enables.
REQ-012 SHALL have port wb_we, input, 1: write request.
REQ-013 SHALL have port wb_cyc, input, 1: cycle request.
REQ-014 SHALL have port wb_ack, output, 1: normal completion.
REQ-015 SHALL have port wb_err, output, 1: error completion.
REQ-016 SHALL have ports ep_tx_addr_0 and ep_rx_addr_0, output, NP*AW: per-port word address, slice p = port p.
REQ-017 SHALL have port ep_tx_data_0, output, NP*DW: per-port write data.
REQ-018 SHALL have port ep_tx_we_0, output, NP: per-port write strobe.
REQ-019 SHALL have port ep_rx_data_1, input, NP*DW: per-port read data, valid RL cycles after ep_rx_re_0/address.
REQ-020 SHALL have port ep_rx_re_0, output, NP: per-port read enable.

Function
REQ-021 SHALL implement the FSM IDLE, RD, RMW_RD, WR, ACK, ERR.
REQ-022 In IDLE with wb_cyc=1, SHALL register addr, sel, wdata and we, then branch as follows.
REQ-023 Port index >= NP: go to ERR; wb_err=1 for one cycle; no strobes; then IDLE.
REQ-024 we=0: go to RD. we=1 with sel all ones: go to WR. we=1 with sel=0: go to ACK with no write. Any other sel: go to RMW_RD.
REQ-025 RD and RMW_RD SHALL assert ep_rx_re_0 only for the selected port and last exactly RL cycles, counted by a down-counter.
REQ-026 On the last RD cycle, SHALL capture the selected port's ep_rx_data_1 slice into the wb_rdata register, then go to ACK.
REQ-027 On the last RMW_RD cycle, SHALL merge the data per byte (wdata where sel=1, read data where sel=0) into the write register, then go to WR.
REQ-028 WR SHALL assert ep_tx_we_0 for the selected port for exactly one cycle, then go to ACK.
REQ-029 ACK SHALL assert wb_ack for exactly one cycle, ignore wb_cyc, then go to IDLE.
REQ-030 A new request SHALL be accepted only from IDLE.
REQ-031 Every port's address slice SHALL carry the registered word address; every port's data slice SHALL carry the write register; strobes SHALL be one-hot or zero.
REQ-032 wb_rdata SHALL hold its last captured value until the next read capture; writes SHALL NOT alter it.
REQ-033 wb_ack and wb_err SHALL never both be 1.
REQ-034 Latency from the IDLE sampling edge to ack SHALL be: full write 2 cycles, read RL+1, partial write RL+2, sel=0 write 1.

Reset
REQ-035 rst SHALL force IDLE, set the counter to 0, and drive wb_ack, wb_err, wb_rdata, all strobes, and the address/data registers to 0.
REQ-036 rst mid-transaction SHALL abort it with no ack, and SHALL drop strobes in the same cycle.

Structure
REQ-037 State encodings and the byte-merge function SHALL be local to the module; no shared package is needed.
REQ-038 No sub-module SHALL be used: single FSM, counter, and data registers.

Verification
REQ-039 NP=2, RL=1, read port1 addr 0x005, model returns 0xCAFEBABE -> re_0=2'b10 for 1 cycle; ack 2 cycles after the sampling edge; rdata=0xCAFEBABE.
REQ-040 Write port0 addr 0x1FF, sel=4'hF, data 0x12345678 -> one we_0=2'b01 pulse with data 0x12345678; ack 2 cycles after.
REQ-041 RL=3, word holds 0xAABBCCDD, write sel=4'b0101 data 0x11223344 -> 3-cycle re, then we with 0xAA22CC44; ack RL+2=5 cycles after.
REQ-042 NP=3, addr port index 3 -> wb_err 1 cycle, wb_ack 0, no re/we; NP=1 with index bit 1 -> same.
REQ-043 Write with sel=0 -> ack after 1 cycle, no strobes; rdata unchanged.
REQ-044 Assert rst during RMW_RD -> strobes 0 immediately, no we, no ack; the next read completes normally.
